// File: rtl/depth_weight_fetch_buffer_if.sv
// Write, read-request and gather-output streams of the depthwise weight buffer.
// The master modport drives the requests; the slave modport is the buffer itself.
interface depth_weight_fetch_buffer_if #(
  parameter int DATA_WIDTH  = 14,
  parameter int KERNEL_TAPS = 25,
  parameter int ADDR_WIDTH  = 12,
  parameter int PAR         = 16
);
  localparam int RW = KERNEL_TAPS * DATA_WIDTH;
  localparam int OW = PAR * RW;

  logic                  wr_start;
  logic [ADDR_WIDTH-1:0] wr_base;
  logic                  wr_valid;
  logic                  wr_ready;
  logic [RW-1:0]         wr_data;
  logic                  rd_req;
  logic [ADDR_WIDTH-1:0] rd_index;
  logic                  rd_ready;
  logic                  rd_err;
  logic                  out_valid;
  logic                  out_ready;
  logic [OW-1:0]         out_data;

  modport master (
    output wr_start, wr_base, wr_valid, wr_data, rd_req, rd_index, out_ready,
    input  wr_ready, rd_ready, rd_err, out_valid, out_data
  );

  modport slave (
    input  wr_start, wr_base, wr_valid, wr_data, rd_req, rd_index, out_ready,
    output wr_ready, rd_ready, rd_err, out_valid, out_data
  );
endinterface

// File: rtl/depth_weight_fetch_buffer.sv
// Purpose: row-per-cycle weight store; gathers PAR consecutive (wrapping) rows into one wide word.
// Latency: out_valid rises PAR+1 edges after the accepting request edge; rd_err one edge after.
// Backpressure: gather held until out_ready; reads own the single RAM port, so writes stall then.
module depth_weight_fetch_buffer #(
  parameter int DATA_WIDTH  = 14,
  parameter int KERNEL_TAPS = 25,
  parameter int DEPTH       = 2480,
  parameter int ADDR_WIDTH  = 12,
  parameter int PAR         = 16
) (
  input logic                         i_clk,
  input logic                         i_rst,
  depth_weight_fetch_buffer_if.slave  bus
);
  localparam int RW = KERNEL_TAPS * DATA_WIDTH;
  localparam int OW = PAR * RW;
  localparam int CW = $clog2(PAR + 1);

  localparam logic [ADDR_WIDTH:0]   LP_DEPTH  = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LP_LAST   = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [CW-1:0]         LP_PAR    = CW'(PAR);
  localparam logic [CW-1:0]         LP_PAR_M1 = CW'(PAR - 1);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_raddr;
  logic [CW-1:0]         r_iss;
  logic                  r_cap_vld;
  logic [CW-1:0]         r_cap_k;
  logic [OW-1:0]         r_out_data;
  logic                  r_rd_err;
  logic [RW-1:0]         r_ram_q;
  logic [RW-1:0]         r_mem [DEPTH];

  logic                  w_rd_rdy;
  logic                  w_wr_rdy;
  logic                  w_idx_bad;
  logic                  w_rd_acc;
  logic                  w_fetch_go;
  logic                  w_wr_acc;
  logic                  w_ram_re;
  logic [ADDR_WIDTH-1:0] w_wr_base_c;
  logic [ADDR_WIDTH-1:0] w_wr_addr;

  function automatic logic [ADDR_WIDTH-1:0] f_inc(input logic [ADDR_WIDTH-1:0] a);
    f_inc = (a == LP_LAST) ? '0 : a + 1'b1;
  endfunction

  assign w_idx_bad   = ({1'b0, bus.rd_index} >= LP_DEPTH);
  assign w_rd_acc    = bus.rd_req & w_rd_rdy;
  assign w_fetch_go  = w_rd_acc & ~w_idx_bad;
  assign w_wr_acc    = bus.wr_valid & w_wr_rdy;
  assign w_ram_re    = (r_state == FETCH) && (r_iss != LP_PAR);
  assign w_wr_base_c = ({1'b0, bus.wr_base} >= LP_DEPTH) ? '0 : bus.wr_base;
  assign w_wr_addr   = bus.wr_start ? w_wr_base_c : r_wr_ptr;

  always_comb begin
    w_state_nxt = r_state;
    w_rd_rdy    = 1'b0;
    case (r_state)
      IDLE: begin
        w_rd_rdy = 1'b1;
        if (bus.rd_req && !w_idx_bad) w_state_nxt = FETCH;
      end
      FETCH: begin
        if (r_cap_vld && (r_cap_k == LP_PAR_M1)) w_state_nxt = HOLD;
      end
      HOLD: begin
        w_rd_rdy = bus.out_ready;
        if (bus.out_ready) w_state_nxt = (bus.rd_req && !w_idx_bad) ? FETCH : IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
    w_wr_rdy = (r_state != FETCH) && !(bus.rd_req && w_rd_rdy);
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state    <= IDLE;
      r_wr_ptr   <= '0;
      r_raddr    <= '0;
      r_iss      <= '0;
      r_cap_vld  <= 1'b0;
      r_cap_k    <= '0;
      r_out_data <= '0;
      r_rd_err   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_rd_err <= w_rd_acc & w_idx_bad;
      if (w_wr_acc)          r_wr_ptr <= f_inc(w_wr_addr);
      else if (bus.wr_start) r_wr_ptr <= w_wr_base_c;
      if (w_fetch_go) begin
        r_raddr <= bus.rd_index;
        r_iss   <= '0;
      end else if (w_ram_re) begin
        r_raddr <= f_inc(r_raddr);
        r_iss   <= r_iss + 1'b1;
      end
      // RAM data lands one edge after the read; remember which slice it belongs to
      r_cap_vld <= w_ram_re;
      r_cap_k   <= r_iss;
      if (r_cap_vld) r_out_data[int'(r_cap_k)*RW +: RW] <= r_ram_q;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_ram_re)      r_ram_q <= r_mem[r_raddr];
    else if (w_wr_acc) r_mem[w_wr_addr] <= bus.wr_data;
  end

  assign bus.wr_ready  = w_wr_rdy;
  assign bus.rd_ready  = w_rd_rdy;
  assign bus.rd_err    = r_rd_err;
  assign bus.out_valid = (r_state == HOLD);
  assign bus.out_data  = r_out_data;
endmodule

// File: tb/tb_depth_weight_fetch_buffer.sv
// Randomised bench for depth_weight_fetch_buffer against an array/modulo reference model.
module tb_depth_weight_fetch_buffer;
  localparam int DW    = 14;
  localparam int KT    = 25;
  localparam int DEPTH = 2480;
  localparam int AW    = 12;
  localparam int PAR   = 16;
  localparam int RW    = KT * DW;
  localparam int OW    = PAR * RW;
  localparam int LAT   = PAR + 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic [RW-1:0] ref_mem [DEPTH];
  int            m_ptr = 0;

  always #5 clk = ~clk;

  depth_weight_fetch_buffer_if #(.DATA_WIDTH(DW), .KERNEL_TAPS(KT), .ADDR_WIDTH(AW), .PAR(PAR)) bus ();

  depth_weight_fetch_buffer #(
    .DATA_WIDTH(DW), .KERNEL_TAPS(KT), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .PAR(PAR)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1);
  end

  function automatic logic [OW-1:0] exp_gather(input int idx);
    logic [OW-1:0] e;
    for (int k = 0; k < PAR; k++) e[k*RW +: RW] = ref_mem[(idx + k) % DEPTH];
    return e;
  endfunction

  function automatic int first_diff(input logic [OW-1:0] a, input logic [OW-1:0] b);
    for (int k = 0; k < PAR; k++) if (a[k*RW +: RW] !== b[k*RW +: RW]) return k;
    return 0;
  endfunction

  function automatic logic [RW-1:0] rand_row();
    logic [RW-1:0] r;
    for (int t = 0; t < KT; t++) r[t*DW +: DW] = DW'($urandom);
    return r;
  endfunction

  // Offer one row for a cycle; reports wr_ready as seen before the edge and updates the model.
  task automatic put_row(input logic st, input logic [AW-1:0] base, input logic [RW-1:0] d,
                         output logic rdy);
    bus.wr_valid = 1'b1; bus.wr_start = st; bus.wr_base = base; bus.wr_data = d;
    #1;
    rdy = bus.wr_ready;
    if (st) m_ptr = (int'(base) >= DEPTH) ? 0 : int'(base);
    if (rdy) begin
      ref_mem[m_ptr] = d;
      m_ptr = (m_ptr + 1) % DEPTH;
    end
    @(posedge clk); #1;
    bus.wr_valid = 1'b0; bus.wr_start = 1'b0;
  endtask

  // Waits for out_valid counting edges after the last edge; lat = edges taken (limit on expiry).
  task automatic wait_valid(input int start, output int lat);
    lat = start;
    while (!bus.out_valid && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic do_fetch(input logic [AW-1:0] idx, output int lat, output logic [OW-1:0] got);
    bus.rd_req = 1'b1; bus.rd_index = idx; bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.rd_req = 1'b0;
    wait_valid(0, lat);
    got = bus.out_data;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
    checks++;
    if (bus.rd_err !== 1'b0) begin errors++; $display("FAIL reset_rd_err got %b want 0", bus.rd_err); end
    checks++;
    if (bus.out_data !== '0) begin errors++; $display("FAIL reset_out_data not zero"); end
    @(posedge clk); #1 rst = 1'b1; #1;
    checks++;
    if (bus.wr_ready !== 1'b1 || bus.rd_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready got wr %b rd %b want 1 1", bus.wr_ready, bus.rd_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_load_all();
    logic rdy;
    int   bad = 0;
    logic [RW-1:0] row;
    for (int r = 0; r < DEPTH; r++) begin
      for (int t = 0; t < KT; t++) row[t*DW +: DW] = DW'((r * 25 + t) % 8192);
      put_row(r == 0, '0, row, rdy);
      if (rdy !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL load_wr_ready got %0d stalled rows want 0", bad); end
    // One more row with no wr_start must land on row 0 once the pointer wraps
    put_row(1'b0, '0, rand_row(), rdy);
    checks++;
    if (rdy !== 1'b1 || m_ptr != 1) begin errors++; $display("FAIL wrap_write ready %b ptr %0d want 1 1", rdy, m_ptr); end
  endtask

  task automatic test_basic_fetch();
    int lat; logic [OW-1:0] got, e; logic [DW-1:0] tap0;
    e = exp_gather(100);
    do_fetch(AW'(100), lat, got);
    checks++;
    if (lat != LAT) begin errors++; $display("FAIL basic_latency got %0d want %0d", lat, LAT); end
    checks++;
    if (got !== e) begin
      errors++; $display("FAIL basic_data slice %0d got %h want %h", first_diff(got, e),
                         got[first_diff(got, e)*RW +: RW], e[first_diff(got, e)*RW +: RW]);
    end
    tap0 = got[DW-1:0];
    checks++;
    if (tap0 !== 14'd2500) begin errors++; $display("FAIL basic_tap0 got %0d want 2500", tap0); end
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL basic_drop got %b want 0", bus.out_valid); end
  endtask

  task automatic test_wrap_fetch();
    int lat; logic [OW-1:0] got, e;
    e = exp_gather(2470);
    do_fetch(AW'(2470), lat, got);
    checks++;
    if (lat != LAT || got !== e) begin
      errors++; $display("FAIL wrap_fetch lat %0d slice %0d got %h want %h", lat, first_diff(got, e),
                         got[first_diff(got, e)*RW +: RW], e[first_diff(got, e)*RW +: RW]);
    end
    checks++;
    if (got[10*RW +: RW] !== ref_mem[0]) begin errors++; $display("FAIL wrap_slice10 got %h want %h", got[10*RW +: RW], ref_mem[0]); end
  endtask

  task automatic test_rd_err();
    int idx;
    for (int i = 0; i < 3; i++) begin
      idx = (i == 0) ? DEPTH : int'($urandom_range(DEPTH, (1 << AW) - 1));
      bus.rd_req = 1'b1; bus.rd_index = AW'(idx);
      #1;
      checks++;
      if (bus.rd_ready !== 1'b1) begin errors++; $display("FAIL err_rd_ready idx %0d got %b want 1", idx, bus.rd_ready); end
      @(posedge clk); #1;
      bus.rd_req = 1'b0;
      checks++;
      if (bus.rd_err !== 1'b1 || bus.out_valid !== 1'b0) begin
        errors++; $display("FAIL err_pulse idx %0d got err %b vld %b want 1 0", idx, bus.rd_err, bus.out_valid);
      end
      @(posedge clk); #1;
      checks++;
      if (bus.rd_err !== 1'b0 || bus.out_valid !== 1'b0 || bus.rd_ready !== 1'b1) begin
        errors++; $display("FAIL err_after idx %0d got err %b vld %b rdy %b want 0 0 1", idx, bus.rd_err, bus.out_valid, bus.rd_ready);
      end
    end
  endtask

  task automatic test_back_to_back();
    int lat, idx, bad; logic rdy; logic [OW-1:0] snap, e, got;
    idx = int'($urandom_range(0, DEPTH - 1));
    snap = exp_gather(idx);
    bus.rd_req = 1'b1; bus.rd_index = AW'(idx); bus.out_ready = 1'b0;
    @(posedge clk); #1;
    bus.rd_req = 1'b0;
    wait_valid(0, lat);
    checks++;
    if (lat != LAT) begin errors++; $display("FAIL hold_latency got %0d want %0d", lat, LAT); end
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      if (bus.out_valid !== 1'b1 || bus.out_data !== snap) bad++;
      if (c == 3) begin
        put_row(1'b1, AW'(idx), rand_row(), rdy);
        if (rdy !== 1'b1) bad++;
      end else begin
        @(posedge clk); #1;
      end
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL hold_stable got %0d bad cycles want 0", bad); end
    e = exp_gather(0);
    bus.out_ready = 1'b1; bus.rd_req = 1'b1; bus.rd_index = '0;
    bus.wr_valid = 1'b1; bus.wr_data = rand_row();
    #1;
    checks++;
    if (bus.rd_ready !== 1'b1 || bus.wr_ready !== 1'b0) begin
      errors++; $display("FAIL b2b_handshake got rd %b wr %b want 1 0", bus.rd_ready, bus.wr_ready);
    end
    @(posedge clk); #1;
    bus.rd_req = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.wr_ready !== 1'b0) begin
      errors++; $display("FAIL b2b_fetch_cycle got vld %b wr %b want 0 0", bus.out_valid, bus.wr_ready);
    end
    bus.wr_valid = 1'b0;
    wait_valid(0, lat);
    got = bus.out_data;
    checks++;
    if (lat != LAT || got !== e) begin
      errors++; $display("FAIL b2b_data lat %0d slice %0d got %h want %h", lat, first_diff(got, e),
                         got[first_diff(got, e)*RW +: RW], e[first_diff(got, e)*RW +: RW]);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_fetch();
    int lat, idx; logic [OW-1:0] got, e;
    bus.rd_req = 1'b1; bus.rd_index = AW'(500); bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.rd_req = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.rd_err !== 1'b0 || bus.out_data !== '0) begin
      errors++; $display("FAIL midreset_outputs got vld %b err %b want 0 0", bus.out_valid, bus.rd_err);
    end
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;
    idx = int'($urandom_range(0, DEPTH - 1));
    e = exp_gather(idx);
    do_fetch(AW'(idx), lat, got);
    checks++;
    if (lat != LAT || got !== e) begin
      errors++; $display("FAIL midreset_refetch lat %0d slice %0d got %h want %h", lat, first_diff(got, e),
                         got[first_diff(got, e)*RW +: RW], e[first_diff(got, e)*RW +: RW]);
    end
  endtask

  task automatic test_random();
    int lat, idx, n, base; logic rdy; logic [OW-1:0] got, e;
    for (int it = 0; it < 8; it++) begin
      base = (it % 3 == 0) ? int'($urandom_range(DEPTH, (1 << AW) - 1)) : int'($urandom_range(0, DEPTH - 1));
      n = int'($urandom_range(1, 20));
      for (int i = 0; i < n; i++) begin
        put_row(i == 0, AW'(base), rand_row(), rdy);
        checks++;
        if (rdy !== 1'b1) begin errors++; $display("FAIL rand_wr_ready it %0d got %b want 1", it, rdy); end
      end
      idx = (it % 2 == 0) ? ((base >= DEPTH) ? 0 : base) : int'($urandom_range(DEPTH - PAR, DEPTH - 1));
      e = exp_gather(idx);
      do_fetch(AW'(idx), lat, got);
      checks++;
      if (lat != LAT || got !== e) begin
        errors++; $display("FAIL rand_fetch it %0d idx %0d lat %0d slice %0d got %h want %h", it, idx, lat,
                           first_diff(got, e), got[first_diff(got, e)*RW +: RW], e[first_diff(got, e)*RW +: RW]);
      end
    end
  endtask

  initial begin
    bus.wr_start = 1'b0; bus.wr_base = '0; bus.wr_valid = 1'b0; bus.wr_data = '0;
    bus.rd_req = 1'b0; bus.rd_index = '0; bus.out_ready = 1'b1;
    test_reset();
    test_load_all();
    test_basic_fetch();
    test_wrap_fetch();
    test_rd_err();
    test_back_to_back();
    test_reset_mid_fetch();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
